// File: rtl/pc_fetch_gen_pkg.sv
// Shared types and helpers for the fetch PC generator.
// Holds the FSM state enumeration and the instruction-size to shift helper.
package pc_fetch_gen_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  // Number of PC low bits that must be zero for an INST_BYTES-aligned address.
  function automatic int inst_shift(input int inst_bytes);
    return $clog2(inst_bytes);
  endfunction

endpackage

// File: rtl/pc_redir_arb.sv
// Fixed-priority redirect arbiter: the lowest-index asserted channel wins.
module pc_redir_arb #(
  parameter int NRED   = 2,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = (NRED > 1) ? $clog2(NRED) : 1
) (
  input  logic [NRED-1:0]        i_valid,
  input  logic [NRED*ADDR_W-1:0] i_addr,
  output logic                   o_valid,
  output logic [IDX_W-1:0]       o_idx,
  output logic [ADDR_W-1:0]      o_addr
);

  // Walk from the highest index down so the lowest asserted channel is written last.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    o_addr  = '0;
    for (int i = NRED - 1; i >= 0; i--) begin
      if (i_valid[i]) begin
        o_valid = 1'b1;
        o_idx   = IDX_W'(i);
        o_addr  = i_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

endmodule

// File: rtl/pc_fetch_gen.sv
// Stage-0 fetch PC generator: sequential advance, prioritised redirects with a
// one-entry pending buffer, alignment check and a saturating accepted-fetch counter.
module pc_fetch_gen
  import pc_fetch_gen_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                INST_BYTES = 4,
  parameter int                NRED       = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_stall,
  input  logic [NRED-1:0]        i_redir_valid,
  input  logic [NRED*ADDR_W-1:0] i_redir_addr,
  input  logic                   i_req_ready,
  output logic [ADDR_W-1:0]      o_pc,
  output logic                   o_ce,
  output logic                   o_req_valid,
  output logic                   o_redir_pend,
  output logic                   o_misalign,
  output logic [CNT_W-1:0]       o_fetch_cnt
);

  localparam int                IDX_W    = (NRED > 1) ? $clog2(NRED) : 1;
  localparam int                SH       = inst_shift(INST_BYTES);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << SH) - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(INST_BYTES);

  fetch_state_t      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic              r_pend;
  logic [ADDR_W-1:0] r_pend_addr;
  logic              r_misalign;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_live_vld;
  logic [IDX_W-1:0]  w_unused_idx;
  logic [ADDR_W-1:0] w_live_addr;
  logic              w_adv;
  logic              w_use_redir;
  logic [ADDR_W-1:0] w_raw_tgt;
  logic [ADDR_W-1:0] w_next_pc;

  pc_redir_arb #(
    .NRED   (NRED),
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_arb (
    .i_valid (i_redir_valid),
    .i_addr  (i_redir_addr),
    .o_valid (w_live_vld),
    .o_idx   (w_unused_idx),
    .o_addr  (w_live_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= BOOT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT: w_state_nxt = RUN;
      RUN:  w_state_nxt = RUN;
    endcase
  end

  assign o_ce        = (r_state == RUN);
  assign o_req_valid = o_ce;
  assign w_adv       = o_ce && i_req_ready && !i_stall;

  // A live redirect beats the buffered one; the buffer beats sequential fetch.
  assign w_use_redir = w_live_vld || r_pend;
  assign w_raw_tgt   = w_live_vld ? w_live_addr : r_pend_addr;
  assign w_next_pc   = w_use_redir ? (w_raw_tgt & ~LOW_MASK) : (r_pc + STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_misalign  <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_misalign <= w_adv && w_use_redir && |(w_raw_tgt & LOW_MASK);
      if (w_adv) begin
        r_pc   <= w_next_pc;
        // Whatever was buffered is either consumed here or superseded by a live redirect.
        r_pend <= 1'b0;
        if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
      end else if (w_live_vld) begin
        r_pend      <= 1'b1;
        r_pend_addr <= w_live_addr;
      end
    end
  end

  assign o_pc         = r_pc;
  assign o_redir_pend = r_pend;
  assign o_misalign   = r_misalign;
  assign o_fetch_cnt  = r_cnt;

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Bench for pc_fetch_gen: directed scenarios plus random traffic against a
// cycle-level reference model; a second instance uses an 8-bit PC and 4-bit counter.
module tb_pc_fetch_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stl = 1'b0;
  logic        rdy = 1'b1;
  logic [1:0]  rv  = '0;
  logic [31:0] ra0 = '0;
  logic [31:0] ra1 = '0;

  logic [31:0] pc32;
  logic        ce32, rq32, pend32, mis32;
  logic [15:0] cnt32;
  logic [7:0]  pc8;
  logic        ce8, rq8, pend8, mis8;
  logic [3:0]  cnt8;

  always #5 clk = ~clk;

  pc_fetch_gen dut (
    .clk           (clk),
    .rst           (rst),
    .i_stall       (stl),
    .i_redir_valid (rv),
    .i_redir_addr  ({ra1, ra0}),
    .i_req_ready   (rdy),
    .o_pc          (pc32),
    .o_ce          (ce32),
    .o_req_valid   (rq32),
    .o_redir_pend  (pend32),
    .o_misalign    (mis32),
    .o_fetch_cnt   (cnt32)
  );

  pc_fetch_gen #(.ADDR_W(8), .CNT_W(4)) dut8 (
    .clk           (clk),
    .rst           (rst),
    .i_stall       (stl),
    .i_redir_valid (rv),
    .i_redir_addr  ({ra1[7:0], ra0[7:0]}),
    .i_req_ready   (rdy),
    .o_pc          (pc8),
    .o_ce          (ce8),
    .o_req_valid   (rq8),
    .o_redir_pend  (pend8),
    .o_misalign    (mis8),
    .o_fetch_cnt   (cnt8)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: architectural PC as a plain integer, buffer as a flag + address.
  bit              m_run;
  longint unsigned m_pc;
  bit              m_pend;
  longint unsigned m_pend_addr;
  bit              m_mis;
  int              m_cnt, m_cnt8;

  task automatic model_edge();
    bit              adv, hit;
    longint unsigned raw;
    if (rst) begin
      m_run = 0; m_pc = 0; m_pend = 0; m_mis = 0; m_cnt = 0; m_cnt8 = 0;
      return;
    end
    adv = m_run && rdy && !stl;
    hit = 0;
    raw = 0;
    if (rv[0])      begin hit = 1; raw = ra0; end
    else if (rv[1]) begin hit = 1; raw = ra1; end
    if (adv) begin
      if (!hit && m_pend) begin hit = 1; raw = m_pend_addr; end
      if (hit) begin
        m_mis = (raw % 4) != 0;
        m_pc  = raw - (raw % 4);
      end else begin
        m_mis = 0;
        m_pc  = (m_pc + 4) % 64'h1_0000_0000;
      end
      m_pend = 0;
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt8 < 15) m_cnt8++;
    end else begin
      m_mis = 0;
      if (hit) begin m_pend = 1; m_pend_addr = raw; end
    end
    m_run = 1;
  endtask

  task automatic compare_all();
    chk("pc",      pc32,  32'(m_pc));
    chk("ce",      32'(ce32),   32'(m_run));
    chk("req_vld", 32'(rq32),   32'(m_run));
    chk("pend",    32'(pend32), 32'(m_pend));
    chk("mis",     32'(mis32),  32'(m_mis));
    chk("cnt",     32'(cnt32),  32'(m_cnt));
    chk("pc8",     32'(pc8),    32'(m_pc % 256));
    chk("ce8",     32'(ce8),    32'(m_run));
    chk("req_vld8",32'(rq8),    32'(m_run));
    chk("pend8",   32'(pend8),  32'(m_pend));
    chk("mis8",    32'(mis8),   32'(m_mis));
    chk("cnt8",    32'(cnt8),   32'(m_cnt8));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    // Boot: two reset cycles, then one BOOT cycle with ce low, then 0, 4, 8.
    cyc(); cyc();
    rst = 1'b0;
    chk("boot_ce0", 32'(ce32), 32'd0);
    chk("boot_pc0", pc32, 32'h0);
    cyc(); chk("boot_pc_a", pc32, 32'h0); chk("boot_ce1", 32'(ce32), 32'd1);
    cyc(); chk("boot_pc_b", pc32, 32'h4);
    cyc(); chk("boot_pc_c", pc32, 32'h8);
    cyc(); cyc();
    chk("pre_stall_pc", pc32, 32'h10);

    // Stall holds pc and counter.
    stl = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_pc", pc32, 32'h10);
      chk("stall_cnt", 32'(cnt32), 32'd4);
    end
    stl = 1'b0;
    cyc(); chk("unstall_pc", pc32, 32'h14);

    // Same-cycle redirects on both channels: channel 0 wins.
    rv = 2'b11; ra0 = 32'h100; ra1 = 32'h200;
    cyc(); chk("prio_pc", pc32, 32'h100); chk("prio_pend", 32'(pend32), 32'd0);
    rv = 2'b00;

    // Blocked redirects: newest buffered entry wins on release.
    rdy = 1'b0; rv = 2'b10; ra1 = 32'h40;
    cyc(); chk("pend_a", 32'(pend32), 32'd1);
    rv = 2'b01; ra0 = 32'h80;
    cyc(); chk("pend_b", 32'(pend32), 32'd1);
    rv = 2'b00; rdy = 1'b1;
    cyc(); chk("pend_pc", pc32, 32'h80); chk("pend_clr", 32'(pend32), 32'd0);

    // Wrap on the 8-bit instance, then a misaligned redirect.
    rv = 2'b01; ra0 = 32'hFC;
    cyc(); chk("wrap_pre", 32'(pc8), 32'hFC);
    rv = 2'b00;
    cyc(); chk("wrap_pc8", 32'(pc8), 32'h00);
    rv = 2'b01; ra0 = 32'h13;
    cyc(); chk("mis_pc", pc32, 32'h10); chk("mis_hi", 32'(mis32), 32'd1);
    rv = 2'b00;
    cyc(); chk("mis_lo", 32'(mis32), 32'd0);

    // Reset while a redirect is pending discards it.
    rdy = 1'b0; rv = 2'b10; ra1 = 32'h300;
    cyc(); chk("rst_pend_set", 32'(pend32), 32'd1);
    rv = 2'b00; rst = 1'b1; rdy = 1'b1;
    cyc();
    chk("rst_pc", pc32, 32'h0); chk("rst_pend", 32'(pend32), 32'd0);
    chk("rst_cnt", 32'(cnt32), 32'd0); chk("rst_ce", 32'(ce32), 32'd0);
    rst = 1'b0;
    cyc(); cyc(); chk("rst_after_pc", pc32, 32'h4);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      stl = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      ra0 = $urandom_range(0, 3) == 0 ? $urandom : ($urandom & 32'hFFFC);
      ra1 = $urandom_range(0, 3) == 0 ? $urandom : ($urandom & 32'hFFFC);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
